fetch_unit: RTL and testbench

Instruction-fetch front end; the producer side of the IF/ID pipeline register. It generates the PC, runs a single-outstanding request/grant/response handshake to instruction memory, and buffers fetched words. It presents {valid, pc, instr} to IF/ID, honours stall from the hazard unit, and applies branch/jump redirects from EX, generating the IF/ID flush.

---
 rtl/cpu_pkg.sv | 8 +
 rtl/fetch_buffer.sv | 57 +++++
 rtl/fetch_unit.sv | 79 +++++++
 tb/tb_fetch_unit.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: datapath width, reset vector and fetch FSM states.
package cpu_pkg;
    localparam int          XLEN      = 32;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {FETCH, WAIT, HOLD, DRAIN} fetch_state_t;
endpackage

// File: rtl/fetch_buffer.sv
// IF/ID output slot plus a one-entry skid that catches a response arriving while the slot is stalled.
module fetch_buffer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clear,
    input  logic            push,
    input  logic            stall,
    input  logic [XLEN-1:0] push_pc,
    input  logic [XLEN-1:0] push_instr,
    output logic            slot_free,
    output logic            skid_valid,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_instr
);
    logic [XLEN-1:0] skid_pc;
    logic [XLEN-1:0] skid_instr;
    logic            pop;

    assign pop       = if_valid && !stall;
    assign slot_free = !if_valid || pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_valid   <= 1'b0;
            if_pc      <= '0;
            if_instr   <= '0;
            skid_valid <= 1'b0;
            skid_pc    <= '0;
            skid_instr <= '0;
        end else if (clear) begin
            if_valid   <= 1'b0;
            skid_valid <= 1'b0;
        end else if (push) begin
            // A push never coincides with a full skid: the FSM stops requesting while it is full.
            if (slot_free) begin
                if_valid <= 1'b1;
                if_pc    <= push_pc;
                if_instr <= push_instr;
            end else begin
                skid_valid <= 1'b1;
                skid_pc    <= push_pc;
                skid_instr <= push_instr;
            end
        end else if (pop) begin
            if (skid_valid) begin
                if_pc      <= skid_pc;
                if_instr   <= skid_instr;
                skid_valid <= 1'b0;
            end else begin
                if_valid <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC generation, single-outstanding imem handshake, redirect/flush.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC,
    parameter int          XLEN     = cpu_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_instr,
    output logic            flush_out
);
    import cpu_pkg::*;

    fetch_state_t    state;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] req_pc;
    logic            slot_free;
    logic            skid_valid;
    logic            push;
    logic            accepted;
    logic            outstanding;

    assign imem_req  = rst_n && (state == FETCH) && !skid_valid;
    assign imem_addr = fetch_pc;
    assign flush_out = rst_n && redirect_valid;
    assign accepted  = imem_req && imem_gnt;
    assign push      = (state == WAIT) && imem_rvalid && !redirect_valid;

    // A response landing in the redirect cycle closes the transaction, so no drain is needed.
    assign outstanding = accepted ||
                         (((state == WAIT) || (state == DRAIN)) && !imem_rvalid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FETCH;
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc & ~XLEN'(3);
            state    <= outstanding ? DRAIN : FETCH;
        end else begin
            case (state)
                FETCH: if (accepted) begin
                    req_pc   <= fetch_pc;
                    fetch_pc <= fetch_pc + XLEN'(4);
                    state    <= WAIT;
                end
                WAIT:  if (imem_rvalid) state <= slot_free ? FETCH : HOLD;
                HOLD:  if (if_valid && !stall) state <= FETCH;
                DRAIN: if (imem_rvalid) state <= FETCH;
                default: state <= FETCH;
            endcase
        end
    end

    fetch_buffer #(.XLEN(XLEN)) u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (redirect_valid),
        .push       (push),
        .stall      (stall),
        .push_pc    (req_pc),
        .push_instr (imem_rdata),
        .slot_free  (slot_free),
        .skid_valid (skid_valid),
        .if_valid   (if_valid),
        .if_pc      (if_pc),
        .if_instr   (if_instr)
    );
endmodule

// File: tb/tb_fetch_unit.sv
// Directed scenarios plus a randomized run against an in-order program-stream reference model.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        flush_out;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
        .flush_out(flush_out)
    );

    // The bench memory never answers while the fetch unit is requesting (one outstanding).
    a_proto: assert property (@(posedge clk) disable iff (!rst_n) imem_rvalid |-> !imem_req);

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        stall = 0; redirect_valid = 0; redirect_pc = '0;
        imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        rst_n = 0;
        cyc();
        rst_n = 1;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        idle();
        rst_n = 0;
        #1;
        chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_flush", {31'b0, flush_out}, 32'd0);
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_if_instr", if_instr, 32'h0);
        cyc();
        rst_n = 1;
        #1;
        chk("first_req", {31'b0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, 32'h0);
        imem_gnt = 1;
        cyc();
        imem_gnt = 0;
        chk("wait_req", {31'b0, imem_req}, 32'd0);
        imem_rvalid = 1; imem_rdata = 32'hAAAA_0001;
        cyc();
        imem_rvalid = 0;
        chk("first_valid", {31'b0, if_valid}, 32'd1);
        chk("first_pc", if_pc, 32'h0);
        chk("first_instr", if_instr, 32'hAAAA_0001);
        chk("next_addr", imem_addr, 32'h4);
    endtask

    task automatic test_stall_hold();
        do_reset();
        stall = 1;
        imem_gnt = 1; cyc(); imem_gnt = 0;
        imem_rvalid = 1; imem_rdata = 32'h11; cyc(); imem_rvalid = 0;
        chk("sh_addr4", imem_addr, 32'h4);
        imem_gnt = 1; cyc(); imem_gnt = 0;
        imem_rvalid = 1; imem_rdata = 32'h22; cyc(); imem_rvalid = 0;
        cyc();
        chk("sh_hold_valid", {31'b0, if_valid}, 32'd1);
        chk("sh_hold_pc", if_pc, 32'h0);
        chk("sh_hold_instr", if_instr, 32'h11);
        chk("sh_hold_req", {31'b0, imem_req}, 32'd0);
        stall = 0;
        cyc();
        chk("sh_skid_valid", {31'b0, if_valid}, 32'd1);
        chk("sh_skid_pc", if_pc, 32'h4);
        chk("sh_skid_instr", if_instr, 32'h22);
        chk("sh_next_req", {31'b0, imem_req}, 32'd1);
        chk("sh_next_addr", imem_addr, 32'h8);
    endtask

    task automatic test_redirect_wait();
        do_reset();
        imem_gnt = 1; cyc(); imem_gnt = 0;
        redirect_valid = 1; redirect_pc = 32'h100;
        #1;
        chk("rw_flush", {31'b0, flush_out}, 32'd1);
        cyc();
        redirect_valid = 0;
        chk("rw_valid", {31'b0, if_valid}, 32'd0);
        chk("rw_drain_req", {31'b0, imem_req}, 32'd0);
        imem_rvalid = 1; imem_rdata = 32'hDEAD; cyc(); imem_rvalid = 0;
        chk("rw_discard", {31'b0, if_valid}, 32'd0);
        chk("rw_req", {31'b0, imem_req}, 32'd1);
        chk("rw_addr", imem_addr, 32'h100);
    endtask

    task automatic test_redirect_gnt();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            imem_gnt = 1; cyc(); imem_gnt = 0;
            imem_rvalid = 1; imem_rdata = 32'h30 + i; cyc(); imem_rvalid = 0;
        end
        chk("rg_addr8", imem_addr, 32'h8);
        imem_gnt = 1; redirect_valid = 1; redirect_pc = 32'h203;
        #1;
        chk("rg_old_addr", imem_addr, 32'h8);
        chk("rg_flush", {31'b0, flush_out}, 32'd1);
        cyc();
        imem_gnt = 0; redirect_valid = 0;
        chk("rg_drain_req", {31'b0, imem_req}, 32'd0);
        chk("rg_valid", {31'b0, if_valid}, 32'd0);
        imem_rvalid = 1; imem_rdata = 32'hBAD; cyc(); imem_rvalid = 0;
        chk("rg_discard", {31'b0, if_valid}, 32'd0);
        chk("rg_req", {31'b0, imem_req}, 32'd1);
        chk("rg_addr", imem_addr, 32'h200);
    endtask

    task automatic test_redirect_stall();
        do_reset();
        stall = 1;
        imem_gnt = 1; cyc(); imem_gnt = 0;
        imem_rvalid = 1; imem_rdata = 32'h55; cyc(); imem_rvalid = 0;
        chk("rs_pre_valid", {31'b0, if_valid}, 32'd1);
        redirect_valid = 1; redirect_pc = 32'h40;
        #1;
        chk("rs_flush", {31'b0, flush_out}, 32'd1);
        cyc();
        redirect_valid = 0;
        chk("rs_valid", {31'b0, if_valid}, 32'd0);
        chk("rs_addr", imem_addr, 32'h40);
        stall = 0;
        imem_gnt = 1; cyc(); imem_gnt = 0;
        imem_rvalid = 1; imem_rdata = 32'h77; cyc(); imem_rvalid = 0;
        chk("rs_pc", if_pc, 32'h40);
        chk("rs_instr", if_instr, 32'h77);
    endtask

    task automatic test_wrap_async();
        do_reset();
        redirect_valid = 1; redirect_pc = 32'hFFFF_FFFE;
        cyc();
        redirect_valid = 0;
        chk("wa_addr_top", imem_addr, 32'hFFFF_FFFC);
        stall = 1;
        imem_gnt = 1; cyc(); imem_gnt = 0;
        imem_rvalid = 1; imem_rdata = 32'h99; cyc(); imem_rvalid = 0;
        chk("wa_pc", if_pc, 32'hFFFF_FFFC);
        chk("wa_wrap_addr", imem_addr, 32'h0);
        imem_gnt = 1; cyc(); imem_gnt = 0;
        chk("wa_pre_valid", {31'b0, if_valid}, 32'd1);
        #2;
        rst_n = 0;
        #1;
        chk("wa_async_valid", {31'b0, if_valid}, 32'd0);
        chk("wa_async_req", {31'b0, imem_req}, 32'd0);
        @(negedge clk);
        rst_n = 1;
    endtask

    // Reference: consumed instructions follow program order from the reset vector,
    // restarting at the word-aligned target after every redirect; each word is memf(pc).
    task automatic test_random();
        logic [31:0] exp_pc = 32'h0;
        logic        pend = 0;
        logic [31:0] pend_addr = '0;
        int          cnt = 0;
        int          consumed = 0;
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            stall          = ($urandom_range(3) == 0);
            redirect_valid = ($urandom_range(39) == 0);
            redirect_pc    = $urandom;
            imem_rvalid    = pend && (cnt == 0);
            imem_rdata     = imem_rvalid ? memf(pend_addr) : $urandom;
            imem_gnt       = imem_req && ($urandom_range(2) != 0);
            #1;
            chk("rnd_flush", {31'b0, flush_out}, {31'b0, redirect_valid});
            if (if_valid && !stall && !redirect_valid) begin
                chk("rnd_pc", if_pc, exp_pc);
                chk("rnd_instr", if_instr, memf(exp_pc));
                exp_pc = exp_pc + 4;
                consumed++;
            end
            if (redirect_valid) exp_pc = redirect_pc & 32'hFFFF_FFFC;
            if (imem_rvalid) pend = 0;
            else if (pend) cnt--;
            if (imem_gnt) begin
                pend = 1; pend_addr = imem_addr; cnt = $urandom_range(2);
            end
            cyc();
        end
        idle();
        total++;
        if (consumed < 200) begin
            bad++;
            $display("FAIL rnd_progress: got %0d instructions expected at least 200", consumed);
        end
    endtask

    initial begin
        test_reset();
        test_stall_hold();
        test_redirect_wait();
        test_redirect_gnt();
        test_redirect_stall();
        test_wrap_async();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
